first_fit_alloc: RTL

FIRST_FIT_ALLOC -- requirements
Module: first_fit_alloc

---
 rtl/first_fit_alloc_pkg.sv | 47 ++++
 rtl/first_fit_alloc_if.sv | 17 +
 rtl/first_fit_alloc_lsu.sv | 63 ++++++
 rtl/first_fit_alloc.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/first_fit_alloc_pkg.sv
// Shared types for the first-fit allocator: LSU op codes, header request/response
// structs, allocator FSM states and the request-size rounding helper.
package allocator_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NULL_ADDR = '0;
  localparam logic [DATA_W-1:0] BLOCK_HEADER_SIZE = 32'd8;
  localparam int ALIGN_BYTES = 8;

  typedef enum logic [2:0] {
    LSU_NOP    = 3'd0,
    LSU_LOAD   = 3'd1,
    LSU_INSERT = 3'd2,
    LSU_DELETE = 3'd3,
    LSU_LOCK   = 3'd4,
    LSU_UNLOCK = 3'd5
  } lsu_op_e;

  typedef struct packed {
    logic              val;
    lsu_op_e           op;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } header_data_req_t;

  typedef struct packed {
    logic              val;
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } header_data_rsp_t;

  typedef enum logic [3:0] {
    S_IDLE, S_CALC, S_LOCK, S_LOAD_HEAD, S_LOAD_CUR, S_CHECK,
    S_SPLIT_REM, S_SPLIT_NEW, S_UNLINK, S_UNLOCK, S_RESPOND
  } alloc_state_e;

  // Bit DATA_W of the result flags overflow of the rounded size plus header.
  function automatic logic [DATA_W:0] calc_need(input logic [DATA_W-1:0] size);
    logic [DATA_W:0] mask;
    logic [DATA_W:0] rounded;
    mask    = (DATA_W+1)'(ALIGN_BYTES - 1);
    rounded = ({1'b0, size} + mask) & ~mask;
    return rounded + {1'b0, BLOCK_HEADER_SIZE};
  endfunction

endpackage

// File: rtl/first_fit_alloc_if.sv
// Allocation request/response handshake bundle between a client and the allocator.
interface first_fit_alloc_if;
  import allocator_pkg::*;

  logic              req_val;
  logic              req_rdy;
  logic [DATA_W-1:0] req_size;
  logic              rsp_val;
  logic              rsp_rdy;
  logic [DATA_W-1:0] rsp_addr;
  logic              rsp_ok;

  modport master (output req_val, req_size, rsp_rdy,
                  input  req_rdy, rsp_val, rsp_addr, rsp_ok);
  modport slave  (input  req_val, req_size, rsp_rdy,
                  output req_rdy, rsp_val, rsp_addr, rsp_ok);
endinterface

// File: rtl/first_fit_alloc_lsu.sv
// Single-outstanding LSU port: latches a command on start_i, holds val until the
// LSU accepts, then waits for the response with lsu_rsp_rdy_o high.
module lsu_req_port
  import allocator_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  header_data_req_t req_i,
  output logic             done_o,
  output header_data_rsp_t rsp_o,
  output header_data_req_t lsu_req_o,
  input  logic             lsu_ready_i,
  input  header_data_rsp_t lsu_rsp_i,
  output logic             lsu_rsp_rdy_o
);

  typedef enum logic [1:0] {P_IDLE, P_ISSUE, P_WAIT} port_state_e;

  port_state_e      state_q, state_d;
  header_data_req_t req_q, req_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= P_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    done_o        = 1'b0;
    lsu_req_o     = '0;
    lsu_rsp_rdy_o = 1'b0;
    rsp_o         = lsu_rsp_i;
    case (state_q)
      P_IDLE: begin
        if (start_i) begin
          req_d     = req_i;
          req_d.val = 1'b1;
          state_d   = P_ISSUE;
        end
      end
      P_ISSUE: begin
        lsu_req_o = req_q;
        if (lsu_ready_i) state_d = P_WAIT;
      end
      P_WAIT: begin
        lsu_rsp_rdy_o = 1'b1;
        if (lsu_rsp_i.val) begin
          done_o  = 1'b1;
          state_d = P_IDLE;
        end
      end
      default: state_d = P_IDLE;
    endcase
  end

endmodule

// File: rtl/first_fit_alloc.sv
// First-fit free-list allocator walking block headers through an LSU.
// Define ALLOC_LOCK_EN to bracket each list walk with LOCK/UNLOCK on the list head.
module first_fit_alloc
  import allocator_pkg::*;
#(
  parameter logic [DATA_W-1:0] FREE_LIST_HEAD = 'h0,
  parameter int unsigned       MIN_SPLIT      = 32,
  parameter int unsigned       MAX_WALK       = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  first_fit_alloc_if.slave    bus,
  output header_data_req_t    lsu_req_o,
  input  logic                lsu_ready_i,
  input  header_data_rsp_t    lsu_rsp_i,
  output logic                lsu_rsp_rdy_o
);

  localparam int WALK_W = $clog2(MAX_WALK + 1);
`ifdef ALLOC_LOCK_EN
  localparam alloc_state_e S_FIRST = S_LOCK;
  localparam alloc_state_e S_LAST  = S_UNLOCK;
`else
  localparam alloc_state_e S_FIRST = S_LOAD_HEAD;
  localparam alloc_state_e S_LAST  = S_RESPOND;
`endif

  alloc_state_e      state_q, state_d;
  logic [DATA_W-1:0] size_q, size_d, need_q, need_d;
  logic [DATA_W-1:0] prev_q, prev_d, cur_q, cur_d;
  logic [DATA_W-1:0] cur_size_q, cur_size_d, cur_next_q, cur_next_d;
  logic [DATA_W-1:0] blk_q, blk_d;
  logic [WALK_W-1:0] walk_q, walk_d;
  logic              ok_q, ok_d, pend_q, pend_d;

  logic              start, lsu_done, op_done, fits;
  header_data_req_t  cmd;
  header_data_rsp_t  lsu_rsp;
  logic [DATA_W:0]   need_calc;
  logic [DATA_W-1:0] rem;

  lsu_req_port u_port (
    .clk_i, .rst_i,
    .start_i(start), .req_i(cmd), .done_o(lsu_done), .rsp_o(lsu_rsp),
    .lsu_req_o, .lsu_ready_i, .lsu_rsp_i, .lsu_rsp_rdy_o
  );

  assign op_done   = lsu_done & lsu_rsp.val;
  assign need_calc = calc_need(size_q);
  assign fits      = cur_size_q >= need_q;
  assign rem       = fits ? (cur_size_q - need_q) : '0;

  assign bus.req_rdy  = (state_q == S_IDLE);
  assign bus.rsp_val  = (state_q == S_RESPOND);
  assign bus.rsp_ok   = ok_q;
  assign bus.rsp_addr = ok_q ? (blk_q + BLOCK_HEADER_SIZE) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;  size_q <= '0;  need_q <= '0;
      prev_q <= '0;  cur_q <= '0;  cur_size_q <= '0;  cur_next_q <= '0;
      blk_q <= '0;  walk_q <= '0;  ok_q <= 1'b0;  pend_q <= 1'b0;
    end else begin
      state_q <= state_d;  size_q <= size_d;  need_q <= need_d;
      prev_q <= prev_d;  cur_q <= cur_d;  cur_size_q <= cur_size_d;  cur_next_q <= cur_next_d;
      blk_q <= blk_d;  walk_q <= walk_d;  ok_q <= ok_d;  pend_q <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;  size_d = size_q;  need_d = need_q;
    prev_d = prev_q;  cur_d = cur_q;  cur_size_d = cur_size_q;  cur_next_d = cur_next_q;
    blk_d = blk_q;  walk_d = walk_q;  ok_d = ok_q;  pend_d = pend_q;
    start = 1'b0;
    cmd = '0;
    cmd.val = 1'b1;
    case (state_q)
      S_LOCK:      begin cmd.op = LSU_LOCK;   cmd.addr = FREE_LIST_HEAD; end
      S_LOAD_HEAD: begin cmd.op = LSU_LOAD;   cmd.addr = FREE_LIST_HEAD; end
      S_LOAD_CUR:  begin cmd.op = LSU_LOAD;   cmd.addr = cur_q; end
      S_SPLIT_REM: begin cmd.op = LSU_INSERT; cmd.addr = cur_q; cmd.size = rem;
                         cmd.next_addr = cur_next_q; end
      S_SPLIT_NEW: begin cmd.op = LSU_INSERT; cmd.addr = cur_q + rem; cmd.size = need_q;
                         cmd.next_addr = NULL_ADDR; end
      S_UNLINK:    begin cmd.op = LSU_DELETE; cmd.addr = prev_q; cmd.next_addr = cur_next_q; end
      S_UNLOCK:    begin cmd.op = LSU_UNLOCK; cmd.addr = FREE_LIST_HEAD; end
      default:     cmd = '0;
    endcase
    // Every state with a command issues it exactly once, then waits for completion.
    if (cmd.op != LSU_NOP) begin
      if (!pend_q) begin
        start  = 1'b1;
        pend_d = 1'b1;
      end else if (op_done) begin
        pend_d = 1'b0;
      end
    end
    case (state_q)
      S_IDLE: if (bus.req_val) begin
        size_d = bus.req_size;  ok_d = 1'b0;  walk_d = '0;  blk_d = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        need_d = need_calc[DATA_W-1:0];
        state_d = (size_q == '0 || need_calc[DATA_W]) ? S_RESPOND : S_FIRST;
      end
      S_LOCK: if (op_done) state_d = S_LOAD_HEAD;
      S_LOAD_HEAD: if (op_done) begin
        prev_d  = FREE_LIST_HEAD;
        cur_d   = lsu_rsp.next_addr;
        state_d = (lsu_rsp.next_addr == NULL_ADDR) ? S_LAST : S_LOAD_CUR;
      end
      S_LOAD_CUR: if (op_done) begin
        cur_size_d = lsu_rsp.size;
        cur_next_d = lsu_rsp.next_addr;
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        if (fits) begin
          state_d = (rem >= DATA_W'(MIN_SPLIT)) ? S_SPLIT_REM : S_UNLINK;
        end else begin
          prev_d  = cur_q;
          cur_d   = cur_next_q;
          walk_d  = walk_q + WALK_W'(1);
          state_d = (cur_next_q == NULL_ADDR || walk_d == WALK_W'(MAX_WALK)) ? S_LAST : S_LOAD_CUR;
        end
      end
      S_SPLIT_REM: if (op_done) state_d = S_SPLIT_NEW;
      S_SPLIT_NEW: if (op_done) begin
        blk_d = cur_q + rem;  ok_d = 1'b1;  state_d = S_LAST;
      end
      S_UNLINK: if (op_done) begin
        blk_d = cur_q;  ok_d = 1'b1;  state_d = S_LAST;
      end
      S_UNLOCK: if (op_done) state_d = S_RESPOND;
      S_RESPOND: if (bus.rsp_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
